// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_pkg
//  Purpose  : Shared encodings for the memory-mapped UART transmitter:
//             FSM state codes, register offsets and STATUS bit positions.
//  Revision : 1.0  initial release
// ============================================================================
package uart_tx_pkg;

    // Serializer states
    localparam logic [1:0] STATE_IDLE  = 2'd0;
    localparam logic [1:0] STATE_START = 2'd1;
    localparam logic [1:0] STATE_DATA  = 2'd2;
    localparam logic [1:0] STATE_STOP  = 2'd3;

    // Register byte offsets from BASE_ADDR
    localparam logic [31:0] TXDATA_OFS = 32'd0;
    localparam logic [31:0] STATUS_OFS = 32'd4;

    // STATUS register bit positions
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_FULL_BIT = 1;
    localparam int STATUS_OVF_BIT  = 2;

endpackage : uart_tx_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock FIFO with occupancy count. A push while full is
//             accepted only when a pop happens on the same edge; a pop while
//             empty is ignored. Head data is presented combinationally.
//  Revision : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == c_FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Storage array: no reset needed, contents are qualified by the count
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/uart_tx_mmio.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_mmio
//  Purpose  : Memory-mapped 8N1 UART transmitter on the core data bus.
//             Stores to TXDATA queue bytes; loads from STATUS return
//             {overflow, full, busy}. Serial output is registered.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_mmio
    import uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h1001_0000,
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Mem_Write_i,
    input  logic        Mem_Read_i,
    input  logic [31:0] Address_i,
    input  logic [31:0] Write_Data_i,
    output logic [31:0] Read_Data_o,
    output logic        Sel_o,
    output logic        Tx_o,
    output logic        Busy_o
);

    localparam int               c_BAUD_W   = $clog2(CLKS_PER_BIT);
    localparam logic [c_BAUD_W-1:0] c_BAUD_MAX = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [31:0]      c_TX_ADDR  = BASE_ADDR + TXDATA_OFS;
    localparam logic [31:0]      c_ST_ADDR  = BASE_ADDR + STATUS_OFS;

    // Address decode and bus strobes
    logic w_hit_tx;
    logic w_hit_st;
    logic w_push_req;
    logic w_ovf_clear;

    // FIFO interface
    logic [7:0]                    w_fifo_data;
    logic                          w_fifo_full;
    logic                          w_fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]   w_fifo_count;
    logic                          w_pop;

    // Serializer state
    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [c_BAUD_W-1:0] r_baud;
    logic [c_BAUD_W-1:0] w_baud_next;
    logic [2:0]          r_bit;
    logic [2:0]          w_bit_next;
    logic [7:0]          r_shift;
    logic [7:0]          w_shift_next;
    logic                r_tx;
    logic                w_tx_next;
    logic                w_baud_done;
    logic                r_ovf;
    logic                w_busy;
    logic [31:0]         w_rdata;
    logic                w_unused_bits;

    assign w_hit_tx    = (Address_i[31:2] == c_TX_ADDR[31:2]);
    assign w_hit_st    = (Address_i[31:2] == c_ST_ADDR[31:2]);
    assign w_push_req  = Mem_Write_i & w_hit_tx;
    assign w_ovf_clear = Mem_Write_i & w_hit_st & Write_Data_i[STATUS_OVF_BIT];
    assign w_baud_done = (r_baud == c_BAUD_MAX);
    assign w_busy      = ~w_fifo_empty | (r_state != STATE_IDLE);

    // Byte-lane bits, address LSBs and the FIFO count are not needed here
    assign w_unused_bits = ^{Address_i[1:0], Write_Data_i[31:8], w_fifo_count};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push_req),
        .i_pop   (w_pop),
        .i_data  (Write_Data_i[7:0]),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // Sticky overflow: set by a dropped push, cleared by a STATUS write with bit 2
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_push_req & w_fifo_full & ~w_pop) begin
            r_ovf <= 1'b1;
        end else if (w_ovf_clear) begin
            r_ovf <= 1'b0;
        end
    end

    // Serializer register bank, including the glitch-free line driver
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= STATE_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
        end
    end

    // Next-state logic: each state holds for CLKS_PER_BIT baud ticks
    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
        w_tx_next    = 1'b1;
        case (r_state)
            STATE_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_fifo_data;
                    w_baud_next  = '0;
                    w_state_next = STATE_START;
                end
            end
            STATE_START: begin
                w_tx_next = 1'b0;
                if (w_baud_done) begin
                    w_baud_next  = '0;
                    w_bit_next   = '0;
                    w_state_next = STATE_DATA;
                end else begin
                    w_baud_next = r_baud + c_BAUD_W'(1);
                end
            end
            STATE_DATA: begin
                w_tx_next = r_shift[0];
                if (w_baud_done) begin
                    w_baud_next  = '0;
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_next = STATE_STOP;
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_next = r_baud + c_BAUD_W'(1);
                end
            end
            STATE_STOP: begin
                if (w_baud_done) begin
                    w_baud_next  = '0;
                    w_state_next = STATE_IDLE;
                end else begin
                    w_baud_next = r_baud + c_BAUD_W'(1);
                end
            end
            default: begin
                w_state_next = STATE_IDLE;
                w_baud_next  = '0;
            end
        endcase
    end

    // STATUS read path; TXDATA and unmapped addresses read as zero
    always_comb begin
        w_rdata = '0;
        if (w_hit_st & Mem_Read_i) begin
            w_rdata[STATUS_BUSY_BIT] = w_busy;
            w_rdata[STATUS_FULL_BIT] = w_fifo_full;
            w_rdata[STATUS_OVF_BIT]  = r_ovf;
        end
    end

    assign Read_Data_o = w_rdata;
    assign Sel_o       = w_hit_tx | w_hit_st;
    assign Tx_o        = r_tx;
    assign Busy_o      = w_busy;

endmodule : uart_tx_mmio
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_mmio
//  Purpose  : Self-checking bench for uart_tx_mmio with an event-level model
//             of the byte queue, frame timing and STATUS register.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_mmio;

    localparam int          C    = 4;
    localparam int          D    = 4;
    localparam logic [31:0] BASE = 32'h1001_0000;
    localparam logic [31:0] STAT = 32'h1001_0004;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_write = 1'b0;
    logic        mem_read = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        sel;
    logic        tx;
    logic        busy;

    always #5 clk = ~clk;

    uart_tx_mmio #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (D)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .Mem_Write_i  (mem_write),
        .Mem_Read_i   (mem_read),
        .Address_i    (addr),
        .Write_Data_i (wdata),
        .Read_Data_o  (rdata),
        .Sel_o        (sel),
        .Tx_o         (tx),
        .Busy_o       (busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: edges since reset, pending bytes, last frame start edge
    int         e = 0;
    logic [7:0] q[$];
    int         nxt_free = 0;
    int         fr_start = 0;
    bit         have_frame = 0;
    logic [7:0] cur_byte = '0;
    bit         m_ovf = 0;

    typedef struct {
        logic [31:0] a;
        logic        rd;
        logic        exp_sel;
        logic [31:0] exp_data;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (edge %0d)", name, act, exp, e);
        end
    endtask

    function automatic logic hit_tx(input logic [31:0] a);
        return (a[31:2] == BASE[31:2]);
    endfunction

    function automatic logic hit_st(input logic [31:0] a);
        return (a[31:2] == STAT[31:2]);
    endfunction

    function automatic logic m_busy();
        return (q.size() > 0) || (have_frame && e >= fr_start && e <= fr_start + 10*C - 1);
    endfunction

    // Line level after edge e: start bit, 8 data bits LSB first, stop bit
    function automatic logic m_tx();
        int o;
        int seg;
        if (!have_frame) return 1'b1;
        o = e - (fr_start + 1);
        if (o < 0 || o >= 10*C) return 1'b1;
        seg = o / C;
        if (seg == 0) return 1'b0;
        if (seg <= 8) return cur_byte[seg-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_status();
        return {29'b0, m_ovf, (q.size() == D), m_busy()};
    endfunction

    // One bus cycle: drive, check current outputs, advance model and clock
    task automatic step(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
        int k;
        int cnt0;
        bit pop;
        mem_write = we;
        mem_read  = re;
        addr      = a;
        wdata     = d;
        #1;
        chk("tx", {31'b0, tx}, {31'b0, m_tx()});
        chk("busy", {31'b0, busy}, {31'b0, m_busy()});
        chk("sel", {31'b0, sel}, {31'b0, hit_tx(a) | hit_st(a)});
        chk("rdata", rdata, (hit_st(a) && re) ? m_status() : 32'b0);
        k    = e + 1;
        cnt0 = q.size();
        pop  = (cnt0 > 0) && (k >= nxt_free);
        if (pop) begin
            cur_byte   = q.pop_front();
            fr_start   = k;
            nxt_free   = k + 10*C + 1;
            have_frame = 1;
        end
        if (we && hit_tx(a)) begin
            if (cnt0 < D || pop) q.push_back(d[7:0]);
            else m_ovf = 1;
        end
        if (we && hit_st(a) && d[2]) m_ovf = 0;
        @(posedge clk);
        e++;
        @(negedge clk);
    endtask

    task automatic idle_step();
        step(1'b0, 1'b1, STAT, 32'b0);
    endtask

    task automatic peek_status(input string name, input logic [31:0] exp);
        mem_write = 1'b0;
        mem_read  = 1'b1;
        addr      = STAT;
        #1;
        chk(name, rdata, exp);
    endtask

    task automatic reset_dut();
        reset     = 1'b1;
        mem_write = 1'b0;
        mem_read  = 1'b1;
        addr      = STAT;
        #1;
        chk("rst_tx", {31'b0, tx}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_status", rdata, 32'd0);
        q.delete();
        have_frame = 0;
        nxt_free   = 0;
        m_ovf      = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        e     = 0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy || m_busy()) && n < budget) begin
            idle_step();
            n++;
        end
        chk("idle_timeout", {31'b0, (n < budget)}, 32'd1);
        idle_step();
    endtask

    initial begin
        logic [9:0]  pat;
        logic        exp_tx;
        int          guard;
        logic [31:0] ra;
        logic        rwe;
        logic        rre;

        @(negedge clk);
        reset_dut();
        repeat (3) idle_step();

        // Single 0x55 frame against a fixed waveform
        pat = {1'b1, 8'h55, 1'b0};
        step(1'b1, 1'b0, BASE, 32'h0000_0055);
        for (int j = 0; j < 44; j++) begin
            if (j < 2 || (j - 2) >= 40) exp_tx = 1'b1;
            else exp_tx = pat[(j - 2) / C];
            chk("t2_wave", {31'b0, tx}, {31'b0, exp_tx});
            idle_step();
        end
        wait_idle(20);

        // Reset in the middle of a frame
        step(1'b1, 1'b0, BASE, 32'h0000_00A3);
        repeat (13) idle_step();
        reset_dut();
        repeat (5) idle_step();

        // Six back-to-back stores: one pops, four queue, sixth overflows
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, BASE, 32'h0000_0010 + i);
        peek_status("t3_status", 32'h7);
        step(1'b1, 1'b0, STAT, 32'h0000_0003);
        peek_status("t3_noclear", 32'h7);
        wait_idle(400);

        // Decode/read table while idle with overflow still set
        vecs[0] = '{BASE,                      1'b1, 1'b1, 32'h0};
        vecs[1] = '{BASE + 32'd3,              1'b1, 1'b1, 32'h0};
        vecs[2] = '{STAT,                      1'b1, 1'b1, 32'h4};
        vecs[3] = '{STAT + 32'd3,              1'b1, 1'b1, 32'h4};
        vecs[4] = '{STAT,                      1'b0, 1'b1, 32'h0};
        vecs[5] = '{BASE + 32'd8,              1'b1, 1'b0, 32'h0};
        vecs[6] = '{32'h1000_0000,             1'b1, 1'b0, 32'h0};
        vecs[7] = '{STAT ^ 32'h8000_0000,      1'b1, 1'b0, 32'h0};
        for (int i = 0; i < 8; i++) begin
            mem_write = 1'b0;
            mem_read  = vecs[i].rd;
            addr      = vecs[i].a;
            #1;
            chk("tbl_sel", {31'b0, sel}, {31'b0, vecs[i].exp_sel});
            chk("tbl_data", rdata, vecs[i].exp_data);
            idle_step();
        end

        // Clear overflow via STATUS bit 2
        step(1'b1, 1'b0, STAT, 32'h0000_0004);
        peek_status("t4_status", 32'h0);
        idle_step();

        // Unmapped store and load
        mem_write = 1'b1;
        mem_read  = 1'b0;
        addr      = BASE + 32'd8;
        wdata     = 32'h0000_00AA;
        #1;
        chk("t5_sel", {31'b0, sel}, 32'd0);
        step(1'b1, 1'b0, BASE + 32'd8, 32'h0000_00AA);
        peek_status("t5_nopush", 32'h0);
        step(1'b0, 1'b1, 32'h1000_0000, 32'b0);
        repeat (3) idle_step();

        // Push while full on the edge the idle serializer pops
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, BASE, 32'h0000_00C0 + i);
        peek_status("t6_full", 32'h3);
        guard = 0;
        while (e + 1 < nxt_free && guard < 100) begin
            idle_step();
            guard++;
        end
        chk("t6_timeout", {31'b0, (guard < 100)}, 32'd1);
        step(1'b1, 1'b0, BASE, 32'h0000_0077);
        peek_status("t6_status", 32'h3);
        wait_idle(400);

        // Randomized bus traffic against the model
        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 4))
                0: ra = BASE;
                1: ra = STAT;
                2: ra = BASE + 32'd8;
                3: ra = BASE + 32'd2;
                default: ra = $urandom;
            endcase
            rwe = ($urandom_range(0, 99) < 30);
            rre = ($urandom_range(0, 1) == 1);
            step(rwe, rre, ra, $urandom);
        end
        wait_idle(600);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_uart_tx_mmio
`default_nettype wire
